// File: rtl/dsky_rx_parser.sv
// Serial command front end: parses framed SYNC/ID/HI/LO/CK byte packets from the UART
// and loads one of five 15-bit DSKY/telemetry input registers per good packet.
module dsky_rx_parser #(
   parameter int unsigned TIMEOUT_CYCLES = 50000,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [7:0]  rx_byte,
   input  logic        rx_valid,
   output logic [14:0] verb_data,
   output logic [14:0] noun_data,
   output logic [14:0] mission_time_data,
   output logic [14:0] apogee_data,
   output logic [14:0] perigee_data,
   output logic        update_pulse,
   output logic [2:0]  update_id,
   output logic [7:0]  err_count
);

   localparam int unsigned       CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_GET_ID = 3'd1;
   localparam logic [2:0] ST_GET_HI = 3'd2;
   localparam logic [2:0] ST_GET_LO = 3'd3;
   localparam logic [2:0] ST_GET_CK = 3'd4;

   logic [2:0]       state;
   logic [2:0]       id_q;
   logic [6:0]       hi_q;
   logic [7:0]       lo_q;
   logic [CNT_W-1:0] idle_cnt;
   logic [7:0]       ck_exp;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Checksum covers the bytes as they appeared on the wire, so the ID/HI fields are zero-extended.
   assign ck_exp = {5'b00000, id_q} ^ {1'b0, hi_q} ^ lo_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state             <= ST_IDLE;
         id_q              <= 3'd0;
         hi_q              <= 7'd0;
         lo_q              <= 8'd0;
         idle_cnt          <= '0;
         verb_data         <= 15'd0;
         noun_data         <= 15'd0;
         mission_time_data <= 15'd0;
         apogee_data       <= 15'd0;
         perigee_data      <= 15'd0;
         update_pulse      <= 1'b0;
         update_id         <= 3'd0;
         err_count         <= 8'd0;
      end else begin
         update_pulse <= 1'b0;
         if (rx_valid) begin
            // A byte always wins over a timeout that would fire in the same cycle.
            idle_cnt <= '0;
            case (state)
               ST_IDLE: begin
                  if (rx_byte == SYNC_BYTE) state <= ST_GET_ID;
               end
               ST_GET_ID: begin
                  if (rx_byte <= 8'd4) begin
                     id_q  <= rx_byte[2:0];
                     state <= ST_GET_HI;
                  end else begin
                     err_count <= sat_inc(err_count);
                     state     <= ST_IDLE;
                  end
               end
               ST_GET_HI: begin
                  if (!rx_byte[7]) begin
                     hi_q  <= rx_byte[6:0];
                     state <= ST_GET_LO;
                  end else begin
                     err_count <= sat_inc(err_count);
                     state     <= ST_IDLE;
                  end
               end
               ST_GET_LO: begin
                  lo_q  <= rx_byte;
                  state <= ST_GET_CK;
               end
               ST_GET_CK: begin
                  if (rx_byte == ck_exp) begin
                     case (id_q)
                        3'd0:    verb_data         <= {hi_q, lo_q};
                        3'd1:    noun_data         <= {hi_q, lo_q};
                        3'd2:    mission_time_data <= {hi_q, lo_q};
                        3'd3:    apogee_data       <= {hi_q, lo_q};
                        3'd4:    perigee_data      <= {hi_q, lo_q};
                        default: ;
                     endcase
                     update_pulse <= 1'b1;
                     update_id    <= id_q;
                  end else begin
                     err_count <= sat_inc(err_count);
                  end
                  state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end else if (state != ST_IDLE) begin
            if (idle_cnt == CNT_LIMIT) begin
               err_count <= sat_inc(err_count);
               state     <= ST_IDLE;
               idle_cnt  <= '0;
            end else begin
               idle_cnt <= idle_cnt + CNT_ONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_dsky_rx_parser.sv
// Directed bench for dsky_rx_parser: packet-level reference model compared every cycle,
// plus literal expectations at the points of interest in each scenario.
module tb_dsky_rx_parser;

   localparam int TO = 16;

   logic        clock;
   logic        reset_n;
   logic [7:0]  rx_byte;
   logic        rx_valid;
   logic [14:0] verb_data, noun_data, mission_time_data, apogee_data, perigee_data;
   logic        update_pulse;
   logic [2:0]  update_id;
   logic [7:0]  err_count;

   int n_checks = 0;
   int n_fail   = 0;

   dsky_rx_parser #(.TIMEOUT_CYCLES(TO), .SYNC_BYTE(8'hA5)) dut (
      .clock(clock), .reset_n(reset_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
      .verb_data(verb_data), .noun_data(noun_data), .mission_time_data(mission_time_data),
      .apogee_data(apogee_data), .perigee_data(perigee_data),
      .update_pulse(update_pulse), .update_id(update_id), .err_count(err_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: collects the bytes of the current packet and judges them by the framing rules.
   logic [14:0] m_regs [5] = '{default: 15'd0};
   logic [7:0]  m_pkt [$];
   int          m_gap   = 0;
   int          m_err   = 0;
   logic        m_pulse = 1'b0;
   int          m_id    = 0;

   task automatic m_reject();
      if (m_err < 255) m_err++;
      m_pkt.delete();
      m_gap = 0;
   endtask

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         foreach (m_regs[i]) m_regs[i] = 15'd0;
         m_pkt.delete();
         m_gap = 0; m_err = 0; m_pulse = 1'b0; m_id = 0;
      end else begin
         m_pulse = 1'b0;
         if (rx_valid) begin
            m_gap = 0;
            if (m_pkt.size() == 0) begin
               if (rx_byte == 8'hA5) m_pkt.push_back(rx_byte);
            end else begin
               m_pkt.push_back(rx_byte);
               if (m_pkt.size() == 2 && rx_byte > 8'd4) m_reject();
               else if (m_pkt.size() == 3 && rx_byte[7]) m_reject();
               else if (m_pkt.size() == 5) begin
                  if (m_pkt[4] == (m_pkt[1] ^ m_pkt[2] ^ m_pkt[3])) begin
                     m_id = int'(m_pkt[1]);
                     m_regs[m_id] = {m_pkt[2][6:0], m_pkt[3]};
                     m_pulse = 1'b1;
                     m_pkt.delete();
                  end else m_reject();
               end
            end
         end else if (m_pkt.size() != 0) begin
            if (m_gap == TO) m_reject();
            else m_gap++;
         end
      end
   end

   always @(negedge clock) begin
      chk("verb",    int'(verb_data),         int'(m_regs[0]));
      chk("noun",    int'(noun_data),         int'(m_regs[1]));
      chk("mtime",   int'(mission_time_data), int'(m_regs[2]));
      chk("apogee",  int'(apogee_data),       int'(m_regs[3]));
      chk("perigee", int'(perigee_data),      int'(m_regs[4]));
      chk("pulse",   int'(update_pulse),      int'(m_pulse));
      chk("upd_id",  int'(update_id),         m_id);
      chk("err",     int'(err_count),         m_err);
   end

   task automatic send(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_byte  = b;
      @(posedge clock);
      #1;
      rx_valid = 1'b0;
      rx_byte  = 8'h00;
   endtask

   task automatic idle(input int n);
      rx_valid = 1'b0;
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic send_pkt(input logic [7:0] id, input logic [7:0] hi, input logic [7:0] lo,
                           input logic [7:0] ck);
      send(8'hA5); send(id); send(hi); send(lo); send(ck);
   endtask

   logic [7:0] b2b [10] = '{8'hA5, 8'h02, 8'h7F, 8'hFF, 8'h82, 8'hA5, 8'h01, 8'h00, 8'h10, 8'h11};
   logic [7:0] slow [5] = '{8'hA5, 8'h04, 8'h00, 8'h05, 8'h01};

   initial begin
      reset_n  = 1'b0;
      rx_valid = 1'b0;
      rx_byte  = 8'h00;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_verb",  int'(verb_data),    0);
      chk("rst_pulse", int'(update_pulse), 0);
      chk("rst_id",    int'(update_id),    0);
      chk("rst_err",   int'(err_count),    0);
      reset_n = 1'b1;
      idle(1);

      // Single verb packet
      send_pkt(8'h00, 8'h00, 8'h23, 8'h23);
      chk("t1_verb",  int'(verb_data),    'h23);
      chk("t1_pulse", int'(update_pulse), 1);
      chk("t1_id",    int'(update_id),    0);
      chk("t1_model", int'(m_regs[0]),    'h23);
      idle(1);
      chk("t1_pulse_off", int'(update_pulse), 0);
      chk("t1_id_hold",   int'(update_id),    0);
      chk("t1_noun",      int'(noun_data),    0);

      // Back-to-back packets, no dead cycle
      for (int i = 0; i < 10; i++) begin
         send(b2b[i]);
         if (i == 4) begin
            chk("t2_mtime", int'(mission_time_data), 'h7FFF);
            chk("t2_pulse_a", int'(update_pulse), 1);
            chk("t2_id_a", int'(update_id), 2);
         end
         if (i == 5) chk("t2_pulse_gap", int'(update_pulse), 0);
         if (i == 9) begin
            chk("t2_noun", int'(noun_data), 'h10);
            chk("t2_pulse_b", int'(update_pulse), 1);
            chk("t2_id_b", int'(update_id), 1);
         end
      end
      chk("t2_err", int'(err_count), 0);

      // Rejections: bad checksum, bad ID, HI bit 7 set
      send_pkt(8'h03, 8'h01, 8'h02, 8'h55);
      chk("t3_apogee", int'(apogee_data), 0);
      chk("t3_pulse",  int'(update_pulse), 0);
      chk("t3_err1",   int'(err_count), 1);
      send(8'hA5); send(8'h07);
      chk("t3_err2", int'(err_count), 2);
      send(8'hA5); send(8'h04); send(8'h80);
      chk("t3_err3", int'(err_count), 3);
      chk("t3_model", m_err, 3);

      // Timeout fires on the 17th idle cycle; trailing bytes are dropped in IDLE
      send(8'hA5); send(8'h04);
      idle(TO);
      chk("t4_err_pre", int'(err_count), 3);
      idle(1);
      chk("t4_err_to", int'(err_count), 4);
      idle(3);
      send(8'h00); send(8'h05); send(8'h01);
      chk("t4_perigee0", int'(perigee_data), 0);
      chk("t4_err_hold", int'(err_count), 4);
      send_pkt(8'h04, 8'h00, 8'h05, 8'h01);
      chk("t4_perigee", int'(perigee_data), 5);
      chk("t4_pulse",   int'(update_pulse), 1);

      // Bytes arriving exactly as the counter reaches the limit are accepted
      idle(2);
      for (int i = 0; i < 5; i++) begin
         send(slow[i]);
         if (i < 4) idle(TO);
      end
      chk("t5_pulse",   int'(update_pulse), 1);
      chk("t5_id",      int'(update_id),    4);
      chk("t5_perigee", int'(perigee_data), 5);
      chk("t5_err",     int'(err_count),    4);

      // Saturation
      for (int i = 0; i < 300; i++) begin
         send(8'hA5); send(8'h09);
      end
      chk("t6_err_sat", int'(err_count), 255);
      chk("t6_model",   m_err, 255);

      // Asynchronous reset mid-packet
      send(8'hA5); send(8'h00); send(8'h00);
      reset_n = 1'b0;
      #1;
      chk("t7_verb",  int'(verb_data),         0);
      chk("t7_mtime", int'(mission_time_data), 0);
      chk("t7_perig", int'(perigee_data),      0);
      chk("t7_id",    int'(update_id),         0);
      chk("t7_err",   int'(err_count),         0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      idle(1);
      send_pkt(8'h01, 8'h00, 8'h42, 8'h43);
      chk("t7_noun",  int'(noun_data),    'h42);
      chk("t7_pulse", int'(update_pulse), 1);
      chk("t7_id2",   int'(update_id),    1);
      chk("t7_err2",  int'(err_count),    0);
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
